// File: rtl/psg_pkg.sv
// ---------------------------------------------------------------------------
// psg_pkg
// Shared constants and types for the SN76489-style PSG register controller.
//   - Channel indices (three tone channels plus the noise channel)
//   - Bit positions of the fields inside a latch byte
//   - Register-type encoding and the reset/silent attenuation value
//   - Busy-timer state type and counter width
// ---------------------------------------------------------------------------
package psg_pkg;

   localparam logic [1:0] CH_TONE0 = 2'd0;
   localparam logic [1:0] CH_TONE1 = 2'd1;
   localparam logic [1:0] CH_TONE2 = 2'd2;
   localparam logic [1:0] CH_NOISE = 2'd3;

   // Latch byte layout: 1 ch[1:0] type d[3:0]
   localparam int LATCH_FLAG = 7;
   localparam int CH_MSB     = 6;
   localparam int CH_LSB     = 5;
   localparam int TYPE_BIT   = 4;

   localparam logic [3:0] ATTEN_SILENT = 4'hF;
   localparam logic       TYPE_TONE    = 1'b0;
   localparam logic       TYPE_ATTEN   = 1'b1;

   // Load value is BUSY_CYCLES-1 <= 254, so 8 bits never wrap.
   localparam int BUSY_CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } busy_state_t;

   // Currently latched register: channel and register type.
   typedef struct packed {
      logic [1:0] ch;
      logic       typ;
   } latch_t;

endpackage

// File: rtl/psg_register_controller_if.sv
// ---------------------------------------------------------------------------
// psg_register_controller_if
// Host write bus of the PSG register controller.
//   data          host write byte (valid with wr_strobe)
//   wr_strobe     single-cycle write request
//   ready         1 = a write will be accepted this cycle
//   write_dropped one-cycle pulse when a write arrived while not ready
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface psg_register_controller_if;

   logic [7:0] data;
   logic       wr_strobe;
   logic       ready;
   logic       write_dropped;

   modport master (
      output data,
      output wr_strobe,
      input  ready,
      input  write_dropped
   );

   modport slave (
      input  data,
      input  wr_strobe,
      output ready,
      output write_dropped
   );

endinterface

// File: rtl/psg_register_controller_write_busy_timer.sv
// ---------------------------------------------------------------------------
// write_busy_timer
// Emulates the chip's READY handshake: after a start pulse, o_ready drops
// for exactly BUSY_CYCLES clock cycles and then returns high.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (returns to IDLE, ready high)
//   i_start  accepted-write pulse; only honoured in IDLE
//   o_ready  registered ready flag
// ---------------------------------------------------------------------------
module write_busy_timer
   import psg_pkg::*;
#(
   parameter int BUSY_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   output logic o_ready
);

   localparam logic [BUSY_CNT_W-1:0] LOAD_VAL = BUSY_CNT_W'(BUSY_CYCLES - 1);

   busy_state_t           r_state;
   logic [BUSY_CNT_W-1:0] r_count;
   logic                  r_ready;

   // The start edge loads BUSY_CYCLES-1; the edge that sees 0 returns to
   // IDLE, so ready is low for BUSY_CYCLES cycles in total.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_BUSY;
                  r_count <= LOAD_VAL;
                  r_ready <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (r_count == '0) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready = r_ready;

endmodule

// File: rtl/psg_register_controller.sv
// ---------------------------------------------------------------------------
// psg_register_controller
// Decodes the SN76489 latch/data byte protocol into per-channel registers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         host write bus: data, wr_strobe, ready, write_dropped
//   o_tone_freq_0..2    10-bit tone period registers
//   o_attenuation_0..3  4-bit attenuation (4'hF silent, index 3 = noise)
//   o_noise_control     {FB, NF[1:0]}
//   o_restart_noise     one-cycle pulse on every noise-control write
// ---------------------------------------------------------------------------
module psg_register_controller
   import psg_pkg::*;
#(
   parameter int COUNTER_BITS = 10,
   parameter int BUSY_CYCLES  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   psg_register_controller_if.slave bus,
   output logic [COUNTER_BITS-1:0] o_tone_freq_0,
   output logic [COUNTER_BITS-1:0] o_tone_freq_1,
   output logic [COUNTER_BITS-1:0] o_tone_freq_2,
   output logic [3:0]              o_attenuation_0,
   output logic [3:0]              o_attenuation_1,
   output logic [3:0]              o_attenuation_2,
   output logic [3:0]              o_attenuation_3,
   output logic [2:0]              o_noise_control,
   output logic                    o_restart_noise
);

   logic [COUNTER_BITS-1:0] r_tone [3];
   logic [3:0]              r_atten [4];
   logic [2:0]              r_noise_control;
   latch_t                  r_latch;
   logic                    r_restart_noise;
   logic                    r_write_dropped;

   logic       w_ready;
   logic       w_accept;
   logic       w_is_latch;
   logic [1:0] w_ch;
   logic       w_type;
   logic       w_noise_wr;

   assign w_accept   = bus.wr_strobe & w_ready;
   assign w_is_latch = bus.data[LATCH_FLAG];

   // A latch byte targets the register it names; a data byte targets the
   // register remembered from the last latch byte.
   assign w_ch   = w_is_latch ? bus.data[CH_MSB:CH_LSB] : r_latch.ch;
   assign w_type = w_is_latch ? bus.data[TYPE_BIT]      : r_latch.typ;

   assign w_noise_wr = w_accept && (w_type == TYPE_TONE) && (w_ch == CH_NOISE);

   write_busy_timer #(
      .BUSY_CYCLES (BUSY_CYCLES)
   ) u_busy_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_accept),
      .o_ready (w_ready)
   );

   // Tone period registers: latch bytes write the low nibble, data bytes
   // write the upper six bits; the other part is held.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_tone
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tone[gi] <= '0;
            end else if (w_accept && (w_type == TYPE_TONE) && (w_ch == 2'(gi))) begin
               if (w_is_latch) begin
                  r_tone[gi][3:0] <= bus.data[3:0];
               end else begin
                  r_tone[gi][COUNTER_BITS-1:4] <= bus.data[COUNTER_BITS-5:0];
               end
            end
         end
      end

      for (genvar gi = 0; gi < 4; gi++) begin : g_atten
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_atten[gi] <= ATTEN_SILENT;
            end else if (w_accept && (w_type == TYPE_ATTEN) && (w_ch == 2'(gi))) begin
               r_atten[gi] <= bus.data[3:0];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_latch         <= '{ch: CH_TONE0, typ: TYPE_TONE};
         r_noise_control <= 3'b000;
         r_restart_noise <= 1'b0;
         r_write_dropped <= 1'b0;
      end else begin
         r_restart_noise <= w_noise_wr;
         r_write_dropped <= bus.wr_strobe & ~w_ready;
         if (w_accept && w_is_latch) begin
            r_latch <= '{ch: bus.data[CH_MSB:CH_LSB], typ: bus.data[TYPE_BIT]};
         end
         if (w_noise_wr) begin
            r_noise_control <= bus.data[2:0];
         end
      end
   end

   assign bus.ready         = w_ready;
   assign bus.write_dropped = r_write_dropped;

   assign o_tone_freq_0   = r_tone[0];
   assign o_tone_freq_1   = r_tone[1];
   assign o_tone_freq_2   = r_tone[2];
   assign o_attenuation_0 = r_atten[0];
   assign o_attenuation_1 = r_atten[1];
   assign o_attenuation_2 = r_atten[2];
   assign o_attenuation_3 = r_atten[3];
   assign o_noise_control = r_noise_control;
   assign o_restart_noise = r_restart_noise;

endmodule

// File: tb/tb_psg_register_controller.sv
// ---------------------------------------------------------------------------
// tb_psg_register_controller
// Directed scenarios followed by random writes, every cycle compared against
// a register-level model of the chip's write protocol.
// ---------------------------------------------------------------------------
module tb_psg_register_controller;

   localparam int BUSY = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   psg_register_controller_if bus_if();

   logic [9:0] tone_0, tone_1, tone_2;
   logic [3:0] att_0, att_1, att_2, att_3;
   logic [2:0] noise_ctl;
   logic       restart;

   psg_register_controller #(
      .COUNTER_BITS (10),
      .BUSY_CYCLES  (BUSY)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus_if.slave),
      .o_tone_freq_0   (tone_0),
      .o_tone_freq_1   (tone_1),
      .o_tone_freq_2   (tone_2),
      .o_attenuation_0 (att_0),
      .o_attenuation_1 (att_1),
      .o_attenuation_2 (att_2),
      .o_attenuation_3 (att_3),
      .o_noise_control (noise_ctl),
      .o_restart_noise (restart)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: chip registers as plain integers.
   int m_tone [3];
   int m_att  [4];
   int m_noise;
   int m_lch;
   int m_ltype;
   int m_busy_left;   // remaining not-ready cycles
   bit m_restart;
   bit m_drop;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_tone[i] = 0;
      for (int i = 0; i < 4; i++) m_att[i] = 15;
      m_noise     = 0;
      m_lch       = 0;
      m_ltype     = 0;
      m_busy_left = 0;
      m_restart   = 0;
      m_drop      = 0;
   endtask

   // One rising edge of the chip as seen from the host.
   task automatic model_edge(input bit stb, input logic [7:0] d);
      m_restart = 0;
      m_drop    = 0;
      if (stb && m_busy_left == 0) begin
         if (d[7]) begin
            m_lch   = int'(d[6:5]);
            m_ltype = int'(d[4]);
         end
         if (m_ltype == 1) begin
            m_att[m_lch] = int'(d[3:0]);
         end else if (m_lch == 3) begin
            m_noise   = int'(d[2:0]);
            m_restart = 1;
         end else if (d[7]) begin
            m_tone[m_lch] = (m_tone[m_lch] / 16) * 16 + int'(d[3:0]);
         end else begin
            m_tone[m_lch] = int'(d[5:0]) * 16 + (m_tone[m_lch] % 16);
         end
         m_busy_left = BUSY;
      end else begin
         if (stb) m_drop = 1;
         if (m_busy_left > 0) m_busy_left--;
      end
   endtask

   task automatic check_all();
      chk("tone_freq_0",   16'(tone_0),    16'(m_tone[0]));
      chk("tone_freq_1",   16'(tone_1),    16'(m_tone[1]));
      chk("tone_freq_2",   16'(tone_2),    16'(m_tone[2]));
      chk("attenuation_0", 16'(att_0),     16'(m_att[0]));
      chk("attenuation_1", 16'(att_1),     16'(m_att[1]));
      chk("attenuation_2", 16'(att_2),     16'(m_att[2]));
      chk("attenuation_3", 16'(att_3),     16'(m_att[3]));
      chk("noise_control", 16'(noise_ctl), 16'(m_noise));
      chk("ready",         16'(bus_if.ready),         16'(m_busy_left == 0));
      chk("restart_noise", 16'(restart),              16'(m_restart));
      chk("write_dropped", 16'(bus_if.write_dropped), 16'(m_drop));
   endtask

   task automatic cycle(input bit stb, input logic [7:0] d);
      @(negedge clk);
      bus_if.wr_strobe = stb;
      bus_if.data      = d;
      @(posedge clk);
      #1;
      model_edge(stb, d);
      check_all();
   endtask

   task automatic wr(input logic [7:0] d);
      cycle(1'b1, d);
      $display("write %02h -> ready=%0b dropped=%0b restart=%0b", d, bus_if.ready,
               bus_if.write_dropped, restart);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100 && !bus_if.ready; i++) cycle(1'b0, 8'h00);
      chk("ready_timeout", 16'(bus_if.ready), 16'd1);
   endtask

   initial begin
      int low_cnt;
      bit stb;
      logic [7:0] d;

      bus_if.wr_strobe = 1'b0;
      bus_if.data      = 8'h00;
      model_reset();

      // Reset state while rst_n is low, then release away from the edge.
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Tone 0 low nibble then high bits; ready window exactly BUSY cycles.
      wr(8'h8E);
      low_cnt = bus_if.ready ? 0 : 1;
      for (int i = 0; i < BUSY; i++) begin
         cycle(1'b0, 8'h00);
         if (!bus_if.ready) low_cnt++;
      end
      chk("ready_low_cycles", 16'(low_cnt), 16'(BUSY));
      wr(8'h0F);
      chk("tone0_0FE", 16'(tone_0), 16'h00FE);
      wait_ready();

      // Noise control via latch and via data byte, one restart pulse each.
      wr(8'hE5);
      chk("noise_latch", 16'(noise_ctl), 16'h0005);
      chk("restart_1", 16'(restart), 16'h0001);
      idle(1);
      chk("restart_1_end", 16'(restart), 16'h0000);
      wait_ready();
      wr(8'h02);
      chk("noise_data", 16'(noise_ctl), 16'h0002);
      chk("restart_2", 16'(restart), 16'h0001);
      wait_ready();

      // Attenuation channel 2.
      wr(8'hD3);
      chk("att2_3", 16'(att_2), 16'h0003);
      wait_ready();
      wr(8'hDF);
      chk("att2_F", 16'(att_2), 16'h000F);
      chk("tone0_kept", 16'(tone_0), 16'h00FE);
      wait_ready();

      // Dropped data byte during busy, then resent.
      wr(8'hA7);
      idle(4);
      wr(8'h15);
      idle(1);
      chk("tone1_low_only", 16'(tone_1), 16'h0007);
      wait_ready();
      wr(8'h15);
      chk("tone1_157", 16'(tone_1), 16'h0157);
      wait_ready();

      // Reset in the middle of a busy window.
      wr(8'hC9);
      chk("tone2_9", 16'(tone_2), 16'h0009);
      idle(9);
      @(negedge clk);
      bus_if.wr_strobe = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_ready", 16'(bus_if.ready), 16'd1);
      chk("rst_tone2", 16'(tone_2), 16'd0);
      chk("rst_restart", 16'(restart), 16'd0);
      #2;
      rst_n = 1'b1;
      wr(8'h3F);
      chk("tone0_3F0", 16'(tone_0), 16'h03F0);
      wait_ready();

      // Held strobe: first cycle accepted, following cycles dropped.
      wr(8'h84);
      wr(8'h05);
      wr(8'h06);
      wait_ready();

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         stb = ($urandom_range(0, 3) == 0);
         d   = 8'($urandom);
         if (stb) wr(d);
         else cycle(1'b0, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
